fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 26 ++
 rtl/fifo_param.sv | 108 ++++++++++
 tb/tb_fifo_param.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and helper function for the parameterised FIFO and its storage array.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  // Ceiling log2, usable in constant expressions at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Unreset register array with one synchronous write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // A read and a write to the same slot in one cycle return the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int ADDR_W  = clog2(DEPTH),
  localparam int CNT_W   = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CNT_W-1:0]  fifo_cnt,
  output logic              overflow,
  output logic              underflow
);

  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
    $error("fifo_param: DATA_W must be within 1..64");
  end
  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of two within 4..256");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_param: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $error("fifo_param: AE_LEVEL must be below AF_LEVEL");
  end

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              has_data;
  logic              wr_acc;
  logic              rd_acc;

  assign empty        = (fifo_cnt == '0);
  assign full         = (fifo_cnt == CNT_W'(DEPTH));
  assign almost_full  = (fifo_cnt >= CNT_W'(AF_LEVEL));
  assign almost_empty = (fifo_cnt <= CNT_W'(AE_LEVEL));

  // A write into a full FIFO still goes through when a read frees the slot in the same cycle.
  assign wr_acc = wr && (!full || rd) && !clr;
  assign rd_acc = rd && !empty && !clr;

  fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re   (rd_acc),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  // The unreset read register is masked until the first read after reset so data_out starts at zero.
  assign data_out = has_data ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      has_data  <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        has_data <= 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      rd_valid <= rd_acc;
      if (wr && full && !rd) overflow <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed vector bench for fifo_param at DEPTH=8, DATA_W=8, AF_LEVEL=6, AE_LEVEL=2.
module tb_fifo_param;

  typedef struct {
    logic       clr;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         cnt;
    logic       rv;
    logic [7:0] dout;
    logic       ovf;
    logic       udf;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr;
  logic       rd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [3:0] fifo_cnt;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;
  vec_t table_q[$];

  fifo_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .wr          (wr),
    .data_in     (data_in),
    .rd          (rd),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .fifo_cnt    (fifo_cnt),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic c, logic w, logic r, logic [7:0] d, int cnt,
                              logic rv, logic [7:0] dout, logic ov, logic ud);
    vec_t v;
    v.clr = c; v.wr = w; v.rd = r; v.din = d; v.cnt = cnt;
    v.rv = rv; v.dout = dout; v.ovf = ov; v.udf = ud;
    return v;
  endfunction

  task automatic check(input string tag, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  // Status flags are derived from the expected occupancy using the default thresholds.
  task automatic checkOutput(input string tag, input vec_t e);
    check(tag, "fifo_cnt", int'(fifo_cnt), e.cnt);
    check(tag, "empty", int'(empty), int'(e.cnt == 0));
    check(tag, "full", int'(full), int'(e.cnt == 8));
    check(tag, "almost_empty", int'(almost_empty), int'(e.cnt <= 2));
    check(tag, "almost_full", int'(almost_full), int'(e.cnt >= 6));
    check(tag, "rd_valid", int'(rd_valid), int'(e.rv));
    check(tag, "data_out", int'(data_out), int'(e.dout));
    check(tag, "overflow", int'(overflow), int'(e.ovf));
    check(tag, "underflow", int'(underflow), int'(e.udf));
  endtask

  task automatic applyStimulus(input vec_t v);
    clr     = v.clr;
    wr      = v.wr;
    rd      = v.rd;
    data_in = v.din;
    @(posedge clk);
    #1;
  endtask

  task automatic stepCheck(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag, v);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 8'h00;
    #2;
    checkOutput("reset", mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, overflow attempt, reads at and below full, drain, empty rd+wr, clear.
    for (int i = 0; i < 8; i++) table_q.push_back(mk(0, 1, 0, 8'(i + 1), i + 1, 0, 8'h00, 0, 0));
    table_q.push_back(mk(0, 1, 0, 8'hAA, 8, 0, 8'h00, 1, 0));
    table_q.push_back(mk(0, 0, 1, 8'h00, 7, 1, 8'h01, 1, 0));
    table_q.push_back(mk(0, 1, 1, 8'h09, 7, 1, 8'h02, 1, 0));
    table_q.push_back(mk(0, 1, 0, 8'h0A, 8, 0, 8'h02, 1, 0));
    table_q.push_back(mk(0, 1, 1, 8'h0B, 8, 1, 8'h03, 1, 0));
    for (int i = 0; i < 8; i++) table_q.push_back(mk(0, 0, 1, 8'h00, 7 - i, 1, 8'(4 + i), 1, 0));
    table_q.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h0B, 1, 0));
    table_q.push_back(mk(0, 1, 1, 8'h0C, 1, 0, 8'h0B, 1, 1));
    table_q.push_back(mk(1, 1, 1, 8'h0D, 0, 0, 8'h0B, 0, 0));
    table_q.push_back(mk(0, 0, 1, 8'h00, 0, 0, 8'h0B, 0, 1));
    table_q.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h0B, 0, 0));

    foreach (table_q[i]) stepCheck($sformatf("vec%0d", i), table_q[i]);

    // Pointer wrap: hold three entries while 20 read/write pairs stream through.
    for (int i = 0; i < 3; i++) stepCheck("wrap_fill", mk(0, 1, 0, 8'(8'h10 + i), i + 1, 0, 8'h0B, 0, 0));
    for (int i = 0; i < 20; i++)
      stepCheck($sformatf("wrap%0d", i), mk(0, 1, 1, 8'(8'h13 + i), 3, 1, 8'(8'h10 + i), 0, 0));
    for (int i = 0; i < 3; i++) stepCheck("wrap_drain", mk(0, 0, 1, 8'h00, 2 - i, 1, 8'(8'h24 + i), 0, 0));

    // Asynchronous reset between edges while entries are stored and rd_valid is high.
    for (int i = 0; i < 6; i++) stepCheck("pre_rst", mk(0, 1, 0, 8'(8'h30 + i), i + 1, 0, 8'h26, 0, 0));
    stepCheck("pre_rst_rd", mk(0, 0, 1, 8'h00, 5, 1, 8'h30, 0, 0));
    wr = 1'b0; rd = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    stepCheck("post_rst_rd", mk(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 1));
    stepCheck("post_rst_wr", mk(0, 1, 0, 8'h55, 1, 0, 8'h00, 0, 1));
    stepCheck("post_rst_rd2", mk(0, 0, 1, 8'h00, 0, 1, 8'h55, 0, 1));

    // Synchronous clear with four entries stored.
    for (int i = 0; i < 4; i++) stepCheck("pre_clr", mk(0, 1, 0, 8'(8'h60 + i), i + 1, 0, 8'h55, 0, 1));
    stepCheck("clr", mk(1, 0, 0, 8'h00, 0, 0, 8'h55, 0, 0));
    stepCheck("post_clr_idle", mk(0, 0, 0, 8'h00, 0, 0, 8'h55, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
